// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: receive side of a 4-slot TDM link.
// Locks on frame_start, rebuilds 4 channels, flags framing errors.
module tdm_demux_1to4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_ch0,
    output logic [WIDTH-1:0] out_ch1,
    output logic [WIDTH-1:0] out_ch2,
    output logic [WIDTH-1:0] out_ch3,
    output logic             out_valid,
    output logic             locked,
    output logic [1:0]       slot,
    output logic             sync_err
);

    typedef enum logic {
        S_HUNT = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_slot;
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_sh2;
    logic [WIDTH-1:0] r_ch0;
    logic [WIDTH-1:0] r_ch1;
    logic [WIDTH-1:0] r_ch2;
    logic [WIDTH-1:0] r_ch3;
    logic             r_valid;
    logic             r_err;

    // Framing FSM: hunt for the marker, then shift beats into
    // shadow slots and publish all four channels on slot 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HUNT;
            r_slot  <= 2'd0;
            r_sh0   <= '0;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_ch0   <= '0;
            r_ch1   <= '0;
            r_ch2   <= '0;
            r_ch3   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (in_valid) begin
                unique case (r_state)
                    S_HUNT: begin
                        if (frame_start) begin
                            r_sh0   <= in_data;
                            r_slot  <= 2'd1;
                            r_state <= S_LOCK;
                        end
                    end
                    S_LOCK: begin
                        if (frame_start) begin
                            // An early marker restarts the frame
                            // here; the partial frame is dropped.
                            r_err  <= (r_slot != 2'd0);
                            r_sh0  <= in_data;
                            r_slot <= 2'd1;
                        end else begin
                            unique case (r_slot)
                                2'd0: begin
                                    r_err   <= 1'b1;
                                    r_state <= S_HUNT;
                                    r_slot  <= 2'd0;
                                end
                                2'd1: begin
                                    r_sh1  <= in_data;
                                    r_slot <= 2'd2;
                                end
                                2'd2: begin
                                    r_sh2  <= in_data;
                                    r_slot <= 2'd3;
                                end
                                2'd3: begin
                                    r_ch0   <= r_sh0;
                                    r_ch1   <= r_sh1;
                                    r_ch2   <= r_sh2;
                                    r_ch3   <= in_data;
                                    r_valid <= 1'b1;
                                    r_slot  <= 2'd0;
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign out_ch0   = r_ch0;
    assign out_ch1   = r_ch1;
    assign out_ch2   = r_ch2;
    assign out_ch3   = r_ch3;
    assign out_valid = r_valid;
    assign locked    = (r_state == S_LOCK);
    assign slot      = r_slot;
    assign sync_err  = r_err;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb_tdm_demux_1to4: directed vectors for tdm_demux_1to4.
// WIDTH=4; expected values written out by hand.
module tb_tdm_demux_1to4;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         frame_start;
    logic [W-1:0] out_ch0;
    logic [W-1:0] out_ch1;
    logic [W-1:0] out_ch2;
    logic [W-1:0] out_ch3;
    logic         out_valid;
    logic         locked;
    logic [1:0]   slot;
    logic         sync_err;

    int n_cmp = 0;
    int n_bad = 0;

    tdm_demux_1to4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .frame_start(frame_start),
        .out_ch0    (out_ch0),
        .out_ch1    (out_ch1),
        .out_ch2    (out_ch2),
        .out_ch3    (out_ch3),
        .out_valid  (out_valid),
        .locked     (locked),
        .slot       (slot),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, return 1ns after the edge.
    task automatic step(input logic v,
                        input logic fs,
                        input logic [W-1:0] d);
        in_valid    = v;
        frame_start = fs;
        in_data     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag,
                           input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input logic [W-1:0] c,
                           input logic [W-1:0] e);
        chk({tag, ".ch0"}, out_ch0, a);
        chk({tag, ".ch1"}, out_ch1, b);
        chk({tag, ".ch2"}, out_ch2, c);
        chk({tag, ".ch3"}, out_ch3, e);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        frame_start = 1'b0;
        in_data = '0;
        step(1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'hF);
        chk_out("rst", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst.valid", out_valid, 0);
        chk("rst.locked", locked, 0);
        chk("rst.slot", slot, 0);
        chk("rst.err", sync_err, 0);
        rst = 1'b0;

        // 1: single frame 0,1,0,0
        step(1'b1, 1'b1, 4'h0);
        chk("t1.locked0", locked, 1);
        chk("t1.slot0", slot, 1);
        chk("t1.err0", sync_err, 0);
        step(1'b1, 1'b0, 4'h1);
        chk("t1.err1", sync_err, 0);
        step(1'b1, 1'b0, 4'h0);
        chk("t1.err2", sync_err, 0);
        chk("t1.valid2", out_valid, 0);
        step(1'b1, 1'b0, 4'h0);
        chk_out("t1", 4'h0, 4'h1, 4'h0, 4'h0);
        chk("t1.valid", out_valid, 1);
        chk("t1.locked", locked, 1);
        chk("t1.slot", slot, 0);
        chk("t1.err3", sync_err, 0);
        step(1'b0, 1'b0, 4'h0);
        chk("t1.pulse", out_valid, 0);

        // 2: back-to-back frames
        step(1'b1, 1'b1, 4'hA);
        step(1'b1, 1'b0, 4'h3);
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'hE);
        chk("t2.v1", out_valid, 1);
        chk_out("t2a", 4'hA, 4'h3, 4'h7, 4'hE);
        step(1'b1, 1'b1, 4'h1);
        chk("t2.gap1", out_valid, 0);
        step(1'b1, 1'b0, 4'h2);
        chk("t2.gap2", out_valid, 0);
        step(1'b1, 1'b0, 4'h3);
        chk("t2.gap3", out_valid, 0);
        chk_out("t2hold", 4'hA, 4'h3, 4'h7, 4'hE);
        step(1'b1, 1'b0, 4'h4);
        chk("t2.v2", out_valid, 1);
        chk_out("t2b", 4'h1, 4'h2, 4'h3, 4'h4);

        // 3: missing marker drops lock
        step(1'b1, 1'b0, 4'h5);
        chk("t3.err", sync_err, 1);
        chk("t3.locked", locked, 0);
        chk("t3.slot", slot, 0);
        chk("t3.valid", out_valid, 0);
        chk_out("t3", 4'h1, 4'h2, 4'h3, 4'h4);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'h6);
            chk("t3.hunt.locked", locked, 0);
            chk("t3.hunt.slot", slot, 0);
            chk("t3.hunt.err", sync_err, 0);
        end
        step(1'b1, 1'b1, 4'h9);
        chk("t3.relock", locked, 1);
        chk("t3.reslot", slot, 1);

        // 4: early marker at slot 2
        step(1'b1, 1'b0, 4'h2);
        chk("t4.slot2", slot, 2);
        step(1'b1, 1'b1, 4'h1);
        chk("t4.err", sync_err, 1);
        chk("t4.valid", out_valid, 0);
        chk("t4.slot", slot, 1);
        chk("t4.locked", locked, 1);
        step(1'b1, 1'b0, 4'h6);
        chk("t4.errclr", sync_err, 0);
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h8);
        chk("t4.v", out_valid, 1);
        chk_out("t4", 4'h1, 4'h6, 4'h7, 4'h8);

        // 5: bubbles inside a frame
        step(1'b1, 1'b1, 4'hC);
        step(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'h0);
            chk("t5.gap.slot", slot, 2);
            chk("t5.gap.valid", out_valid, 0);
        end
        step(1'b1, 1'b0, 4'hE);
        chk("t5.v3", out_valid, 0);
        step(1'b1, 1'b0, 4'hF);
        chk("t5.v", out_valid, 1);
        chk_out("t5", 4'hC, 4'hD, 4'hE, 4'hF);

        // 6: reset mid-frame
        step(1'b1, 1'b1, 4'h5);
        step(1'b1, 1'b0, 4'h6);
        step(1'b1, 1'b0, 4'h7);
        chk("t6.slot3", slot, 3);
        rst = 1'b1;
        step(1'b1, 1'b0, 4'h8);
        rst = 1'b0;
        chk_out("t6rst", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("t6.locked", locked, 0);
        chk("t6.slot", slot, 0);
        chk("t6.valid", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'h9);
            chk("t6.post.valid", out_valid, 0);
            chk("t6.post.locked", locked, 0);
        end
        chk_out("t6end", 4'h0, 4'h0, 4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
